// File: rtl/tiny_input_cond.sv
// ----------------------------------------------------------------------------
// tiny_input_cond
//   Input-conditioning stage in front of the 4-bit up/down counter core.
//   Each raw pad input (test, up/down, enable) is synchronised into clk,
//   debounced with a stable-count filter, and presented as a clean level
//   plus one-cycle rise/fall pulses. A prescaler turns the debounced enable
//   into a periodic one-cycle step strobe for the counter.
//
// Parameters
//   DEB_CYCLES : consecutive stable cycles needed to accept a new level (1..65536)
//   PRESCALE   : step_o period in cycles while enable is held (1..65536)
//
// Ports
//   clk       in  : single clock, rising edge
//   rst       in  : synchronous active-high reset
//   test_raw  in  : raw test input (asynchronous)
//   ud_raw    in  : raw up/down select, 1 = up (asynchronous)
//   en_raw    in  : raw count enable (asynchronous)
//   test_o    out : debounced test level
//   ud_o      out : debounced up/down level
//   en_o      out : debounced enable level
//   rise_o    out : [0]=test [1]=ud [2]=en one-cycle rising-edge pulses
//   fall_o    out : same bit order, one-cycle falling-edge pulses
//   step_o    out : one-cycle step strobe, only while en_o is 1
// ----------------------------------------------------------------------------
module tiny_input_cond #(
    parameter int DEB_CYCLES = 16,
    parameter int PRESCALE   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       test_raw,
    input  logic       ud_raw,
    input  logic       en_raw,
    output logic       test_o,
    output logic       ud_o,
    output logic       en_o,
    output logic [2:0] rise_o,
    output logic [2:0] fall_o,
    output logic       step_o
);

    // Counters are sized to hold their terminal value; a 1-cycle setting
    // still needs a 1-bit counter that simply stays at 0.
    localparam int DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
    localparam logic [PCW-1:0] PRE_LAST = PCW'(PRESCALE - 1);

    // Channel index: 0 = test, 1 = ud, 2 = en.
    logic [2:0]     raw;
    logic [2:0]     s1_q;
    logic [2:0]     s2_q;
    logic [2:0]     lvl_q,  lvl_d;
    logic [2:0]     rise_q, rise_d;
    logic [2:0]     fall_q, fall_d;
    logic [DCW-1:0] dcnt_q [3];
    logic [DCW-1:0] dcnt_d [3];
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic           step_q, step_d;

    assign raw = {en_raw, ud_raw, test_raw};

    // Debounce: any agreement with the accepted level wipes the pending
    // count, so only an unbroken run of DEB_CYCLES disagreeing samples
    // moves the level.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // leaves one unassigned and no latch is inferred.
        lvl_d  = lvl_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < 3; i++) begin
            dcnt_d[i] = dcnt_q[i];
            if (s2_q[i] == lvl_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DEB_LAST) begin
                dcnt_d[i] = '0;
                lvl_d[i]  = s2_q[i];
                rise_d[i] = s2_q[i];
                fall_d[i] = ~s2_q[i];
            end else begin
                dcnt_d[i] = dcnt_q[i] + DCW'(1);
            end
        end
    end

    // Prescaler: free-runs only while the debounced enable is high and is
    // held at 0 otherwise, so every new enable starts a full period.
    always_comb begin
        pcnt_d = '0;
        step_d = 1'b0;
        if (lvl_q[2]) begin
            if (pcnt_q == PRE_LAST) begin
                step_d = 1'b1;
            end else begin
                pcnt_d = pcnt_q + PCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, which is what makes s1 -> s2 a real
        // two-stage synchroniser.
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            lvl_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            dcnt_q <= '{default: '0};
            pcnt_q <= '0;
            step_q <= 1'b0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            dcnt_q <= dcnt_d;
            pcnt_q <= pcnt_d;
            step_q <= step_d;
        end
    end

    assign test_o = lvl_q[0];
    assign ud_o   = lvl_q[1];
    assign en_o   = lvl_q[2];
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign step_o = step_q;

endmodule

// File: doc/tiny_input_cond.md
# tiny_input_cond

Input-conditioning stage that sits directly upstream of the 4-bit up/down counter core. It takes the three raw pad inputs (test, up/down, enable) and does four things:
- synchronises each into the `clk` domain;
- debounces each with a stable-count filter;
- emits clean levels and single-cycle rise/fall pulses;
- generates a prescaled `step_o` strobe that the counter uses as its per-step enable, instead of counting on every clock while enable is held.

## Interface

Parameters:
- `DEB_CYCLES`, default 16: consecutive stable cycles required to accept a new input level. Legal range 1..65536.
- `PRESCALE`, default 4: period in cycles of `step_o` while enable is held. Legal range 1..65536.

Ports:
- `clk` in 1: the block's one clock. All state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `test_raw` in 1: raw test input, asynchronous to `clk`.
- `ud_raw` in 1: raw up/down select (1 = up), asynchronous.
- `en_raw` in 1: raw count enable, asynchronous.
- `test_o` out 1: debounced test level.
- `ud_o` out 1: debounced up/down level.
- `en_o` out 1: debounced enable level.
- `rise_o` out 3: one-cycle rising-edge pulses of the debounced levels. Bit 0 = test, bit 1 = ud, bit 2 = en.
- `fall_o` out 3: one-cycle falling-edge pulses, same bit order as `rise_o`.
- `step_o` out 1: one-cycle step strobe, active only while `en_o` is 1.

## Operation

Three identical channels (test, ud, en) plus one prescaler.

Per channel:
- **Synchroniser:** two flops, `s1` then `s2`.
- **Debounce state:** accepted level `lvl` and counter `dcnt`, sized to hold `DEB_CYCLES-1`.
- **Each cycle, if `s2 == lvl`:** clear `dcnt` to 0. Any disagreement shorter than `DEB_CYCLES` cycles is discarded entirely.
- **Each cycle, if `s2 != lvl` and `dcnt == DEB_CYCLES-1`:** set `lvl <= s2` and clear `dcnt` to 0.
- **Each cycle, if `s2 != lvl` otherwise:** increment `dcnt`.
- **Edge pulses:** on the same edge that `lvl` goes 0→1, set the channel's `rise_o` bit for exactly one cycle. On a 1→0 acceptance, set its `fall_o` bit for exactly one cycle. All other cycles: 0.
- **Level outputs:** `test_o`, `ud_o`, `en_o` are the registered `lvl` values.

Prescaler:
- **Counter:** `pcnt`, sized to hold `PRESCALE-1`.
- **If `en_o == 0`:** `pcnt <= 0` and `step_o <= 0`.
- **Else if `pcnt == PRESCALE-1`:** `pcnt <= 0` and `step_o <= 1`.
- **Else:** `pcnt <= pcnt+1` and `step_o <= 0`.
- **`PRESCALE = 1`:** `step_o` is high every cycle after the first, while `en_o` is 1.

Reset:
- While `rst` is sampled high, at the next edge all of the following become 0: `s1`, `s2`, `lvl`, `dcnt`, `pcnt`, `rise_o`, `fall_o`, `step_o`.
- Consequently every output reads 0 in the cycle after reset.
- Reset mid-operation aborts any pending debounce count. It never produces a rise or fall pulse, even if `lvl` was 1 before reset.

Boundary conditions:
- The channels are independent. Simultaneous acceptances on several channels produce simultaneous pulses.
- A raw input that is already 1 when reset is released is accepted as a fresh rise, with a `rise_o` pulse, after the normal latency.
- `dcnt` and `pcnt` never exceed their terminal values. No wrap path other than the explicit clear.

## Timing

- **Synchroniser:** if a raw input changes before edge k, `s1` takes it at edge k and `s2` at edge k+1.
- **Debounce latency:** if the raw value then stays stable, `lvl`, the level output, and the matching `rise_o`/`fall_o` pulse all update at edge k+1+`DEB_CYCLES`. For example, `DEB_CYCLES=1` gives an update at edge k+2.
- **Glitch rejection:** a raw pulse that `s2` holds for fewer than `DEB_CYCLES` consecutive cycles causes no output change.
- **First step:** if `en_o` rises at edge E, `step_o` is first high after edge E+`PRESCALE`. It then pulses every `PRESCALE` edges.
- **Stopping:** if `en_o` falls at edge F, `step_o` is 0 from edge F+1 onward and `pcnt` is 0 at edge F+1. A step pulse coinciding with edge F is allowed.
- **Pipelining:** every output is registered. No combinational path runs from any input to any output.

## Test plan

All scenarios use `DEB_CYCLES=4`, `PRESCALE=3`.

1. **Reset values:** hold `rst` high for 3 cycles with all raw inputs at 1 → all outputs are 0 while reset is held. After release at edge R, `test_o`, `ud_o` and `en_o` go to 1 and `rise_o` = 3'b111 for exactly one cycle at edge R+5.
2. **Clean press on up/down:** `ud_raw` goes 0→1 before edge 10 → `ud_o` = 1 and `rise_o[1]` = 1 at edge 15 only. Then `ud_raw` goes 1→0 before edge 30 → `ud_o` = 0 and `fall_o[1]` pulses at edge 35.
3. **Glitch rejection:** `test_raw` is high for 3 cycles, then low → `test_o` stays 0 and no `rise_o`/`fall_o` pulse occurs.
4. **Bounce restart:** `en_raw` goes high, drops low for 1 cycle after 2 high cycles, then stays high → acceptance is delayed so that 4 consecutive high cycles of `s2` follow the drop, and exactly one `rise_o[2]` pulse is produced.
5. **Step generation:** `en_o` rises at edge E → `step_o` is high after edges E+3, E+6, E+9. Deassert `en_raw` → `step_o` is 0 from one edge after `en_o` falls. Re-enable → the first step is again exactly 3 edges after the new `en_o` rise.
6. **Reset mid-debounce:** `ud_raw` goes high, and `rst` is pulsed 2 cycles later → `ud_o` = 0 and there is no pulse during or right after reset. The level is accepted 5 edges after `s1` re-samples it post-release.
